// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives pc/iread to the icache, captures returned words
// into a one-entry buffer, and handles redirects, including ones that arrive mid-miss.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h00000000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ibusywait,
    input  logic [31:0]          instruction,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          pc,
    output logic                 iread,
    output logic [31:0]          instr_out,
    output logic                 instr_valid,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic                 iread_q, iread_d;
    logic [31:0]          instr_out_q, instr_out_d;
    logic                 instr_valid_q, instr_valid_d;
    logic [CNT_WIDTH-1:0] fetch_count_q, fetch_count_d;
    logic                 pend_q, pend_d;
    logic [31:0]          pend_pc_q, pend_pc_d;
    logic [31:0]          target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        iread_d       = iread_q;
        instr_out_d   = instr_out_q;
        instr_valid_d = instr_valid_q;
        fetch_count_d = fetch_count_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                iread_d = 1'b1;
                if (redirect) begin
                    pc_d          = target;
                    instr_valid_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (ibusywait) begin
                    // pc must stay put during a miss; remember the redirect for later.
                    if (redirect) begin
                        pend_d        = 1'b1;
                        pend_pc_d     = target;
                        instr_valid_d = 1'b0;
                    end
                end else if (redirect) begin
                    pc_d          = target;
                    instr_valid_d = 1'b0;
                    pend_d        = 1'b0;
                end else if (pend_q) begin
                    pc_d   = pend_pc_q;
                    pend_d = 1'b0;
                end else begin
                    instr_out_d   = instruction;
                    instr_valid_d = 1'b1;
                    if (fetch_count_q != CNT_MAX) begin
                        fetch_count_d = fetch_count_q + CNT_ONE;
                    end
                    if (stall) begin
                        state_d = S_HOLD;
                        iread_d = 1'b0;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d          = target;
                    instr_valid_d = 1'b0;
                    iread_d       = 1'b1;
                    state_d       = S_FETCH;
                end else if (!stall) begin
                    pc_d    = pc_q + 32'd4;
                    iread_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
                iread_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= PC_RESET;
            iread_q       <= 1'b0;
            instr_out_q   <= 32'h0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
            pend_q        <= 1'b0;
            pend_pc_q     <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            iread_q       <= iread_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            fetch_count_q <= fetch_count_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

    assign pc          = pc_q;
    assign iread       = iread_q;
    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed icache/CPU stimulus, a transaction-level
// reference model checked every cycle, and literal checkpoints at key moments.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ibusywait = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instruction;

    logic [31:0] pc, instr_out, pc4, instr_out4, instruction4;
    logic        iread, instr_valid, iread4, instr_valid4;
    logic [15:0] fetch_count;
    logic [3:0]  fetch_count4;

    int n_checks = 0;
    int n_fail = 0;

    // Icache stand-in: the word at an address is address ^ A5A50000.
    assign instruction  = pc ^ 32'hA5A50000;
    assign instruction4 = pc4 ^ 32'hA5A50000;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .ibusywait(ibusywait), .instruction(instruction),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc), .iread(iread), .instr_out(instr_out), .instr_valid(instr_valid),
        .fetch_count(fetch_count)
    );

    instr_fetch_unit #(.PC_RESET(32'h0), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .ibusywait(ibusywait), .instruction(instruction4),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc(pc4), .iread(iread4), .instr_out(instr_out4), .instr_valid(instr_valid4),
        .fetch_count(fetch_count4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: "started" marks the post-reset idle cycle is over,
    // "req" means a request is outstanding, otherwise the CPU is holding.
    logic        m_live = 1'b0;
    logic        m_started, m_req, m_valid, m_pend, m_done;
    logic [31:0] m_pc, m_instr, m_tgt;
    int          m_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] tgt;

    always @(posedge clk) begin
        tgt = {redirect_pc[31:2], 2'b00};
        m_done <= 1'b0;
        if (reset) begin
            m_live <= 1'b1; m_started <= 1'b0; m_req <= 1'b0; m_valid <= 1'b0;
            m_pend <= 1'b0; m_pc <= 32'h0; m_instr <= 32'h0; m_tgt <= 32'h0; m_cnt <= 0;
            exp_q.delete();
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_req <= 1'b1;
            if (redirect) begin m_pc <= tgt; m_valid <= 1'b0; end
        end else if (m_req) begin
            if (ibusywait) begin
                if (redirect) begin m_pend <= 1'b1; m_tgt <= tgt; m_valid <= 1'b0; end
            end else if (redirect) begin
                m_pc <= tgt; m_valid <= 1'b0; m_pend <= 1'b0;
            end else if (m_pend) begin
                m_pc <= m_tgt; m_pend <= 1'b0;
            end else begin
                m_instr <= m_pc ^ 32'hA5A50000;
                exp_q.push_back(m_pc ^ 32'hA5A50000);
                m_done <= 1'b1;
                m_valid <= 1'b1;
                m_cnt <= m_cnt + 1;
                if (stall) m_req <= 1'b0;
                else m_pc <= m_pc + 32'd4;
            end
        end else begin
            if (redirect) begin m_pc <= tgt; m_valid <= 1'b0; m_req <= 1'b1; end
            else if (!stall) begin m_pc <= m_pc + 32'd4; m_req <= 1'b1; end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("pc", pc, m_pc);
            check("iread", {31'h0, iread}, {31'h0, m_req});
            check("instr_out", instr_out, m_instr);
            check("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
            check("fetch_count", {16'h0, fetch_count}, (m_cnt > 65535) ? 32'hFFFF : m_cnt);
            check("fetch_count4", {28'h0, fetch_count4}, (m_cnt > 15) ? 32'hF : m_cnt);
            check("pc4", pc4, m_pc);
            if (m_done) begin
                if (exp_q.size() == 0) check("sb_empty", 32'h0, 32'h1);
                else check("sb_word", instr_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_iread", {31'h0, iread}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_count", {16'h0, fetch_count}, 32'h0);
        reset = 1'b0;
        tick();
        check("idle_exit_iread", {31'h0, iread}, 32'h1);
        check("idle_exit_pc", pc, 32'h0);
        repeat (4) tick();
        check("stream_pc", pc, 32'h10);
        check("stream_count", {16'h0, fetch_count}, 32'd4);
        check("stream_instr", instr_out, 32'hA5A5000C);

        // 20-cycle miss at 0x10
        ibusywait = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("miss_pc", pc, 32'h10);
            check("miss_iread", {31'h0, iread}, 32'h1);
        end
        ibusywait = 1'b0;
        tick();
        check("miss_done_pc", pc, 32'h14);
        check("miss_done_instr", instr_out, 32'hA5A50010);
        check("miss_done_count", {16'h0, fetch_count}, 32'd5);

        // stall right as the 0x20 fetch completes
        repeat (3) tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_iread", {31'h0, iread}, 32'h0);
            check("hold_pc", pc, 32'h20);
            check("hold_instr", instr_out, 32'hA5A50020);
            check("hold_valid", {31'h0, instr_valid}, 32'h1);
        end
        stall = 1'b0;
        tick();
        check("unstall_pc", pc, 32'h24);
        check("unstall_iread", {31'h0, iread}, 32'h1);

        // redirect to 0x103 during a 10-cycle miss at 0x40
        repeat (7) tick();
        check("pre_redir_pc", pc, 32'h40);
        check("pre_redir_count", {16'h0, fetch_count}, 32'd16);
        ibusywait = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        check("redir_miss_valid", {31'h0, instr_valid}, 32'h0);
        check("redir_miss_pc", pc, 32'h40);
        repeat (8) tick();
        ibusywait = 1'b0;
        tick();
        check("redir_pc", pc, 32'h100);
        check("redir_count", {16'h0, fetch_count}, 32'd16);
        tick();
        check("redir_instr", instr_out, 32'hA5A50100);
        check("redir_next_pc", pc, 32'h104);

        // two redirects during one miss: the later one wins
        ibusywait = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h404;
        tick();
        redirect = 1'b0;
        tick();
        ibusywait = 1'b0;
        tick();
        check("last_wins_pc", pc, 32'h404);
        check("last_wins_count", {16'h0, fetch_count}, 32'd17);

        // redirect on a hit to the top of the address space, then wrap
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFF;
        tick();
        redirect = 1'b0;
        check("top_pc", pc, 32'hFFFFFFFC);
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_instr", instr_out, 32'h5A5AFFFC);
        check("wrap_count", {16'h0, fetch_count}, 32'd18);

        // redirect while holding wins over stall
        stall = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0; stall = 1'b0;
        check("hold_redir_pc", pc, 32'h80);
        check("hold_redir_iread", {31'h0, iread}, 32'h1);
        check("hold_redir_valid", {31'h0, instr_valid}, 32'h0);
        repeat (6) tick();
        check("sat_count4", {28'h0, fetch_count4}, 32'hF);
        check("wide_count", {16'h0, fetch_count}, 32'd25);

        // reset in the middle of a miss with a redirect pending
        ibusywait = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h500;
        tick();
        redirect = 1'b0; reset = 1'b1;
        tick();
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_iread", {31'h0, iread}, 32'h0);
        check("mid_rst_instr", instr_out, 32'h0);
        check("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        check("mid_rst_count", {16'h0, fetch_count}, 32'h0);
        reset = 1'b0; ibusywait = 1'b0;
        tick();
        check("post_rst_iread", {31'h0, iread}, 32'h1);
        check("post_rst_pc", pc, 32'h0);
        tick();
        check("post_rst_pc2", pc, 32'h4);
        check("post_rst_count", {16'h0, fetch_count}, 32'd1);
        check("post_rst_instr", instr_out, 32'hA5A50000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the CPU-to-icache fetch interface. It drives pc and iread into icache, waits on ibusywait, and captures the returned instruction word.
- Holds the captured word in a one-entry buffer for the CPU while the CPU is stalled, for example on dbusywait.
- Handles branch/jump redirects, including a redirect that arrives while an icache miss is still outstanding.

Parameters:
- PC_RESET, 32'h00000000, pc value loaded by reset.
- CNT_WIDTH, 16, width of the saturating completed-fetch counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- ibusywait  input  1  icache busy; 1 = requested word not yet available.
- instruction  input  32  icache read data; valid when iread=1 and ibusywait=0.
- stall  input  1  CPU cannot accept a new instruction this cycle.
- redirect  input  1  one-cycle pulse: change fetch address to redirect_pc.
- redirect_pc  input  32  target address; bits [1:0] ignored and forced to 0.
- pc  output  32  current fetch address to icache (icache uses pc[9:0]).
- iread  output  1  fetch request to icache.
- instr_out  output  32  buffered instruction for the CPU.
- instr_valid  output  1  instr_out holds a valid, un-flushed instruction.
- fetch_count  output  CNT_WIDTH  completed, non-discarded fetches; saturates at all-ones.

Behaviour:
- Reset (synchronous, at any time, including mid-miss):
  - pc=PC_RESET, iread=0, instr_out=0, instr_valid=0, fetch_count=0.
  - Redirect-pending flag cleared; state=IDLE.
- State IDLE:
  - iread=0.
  - Next cycle goes to FETCH unconditionally, giving exactly one idle cycle after reset is released.
- State FETCH:
  - iread=1 (registered output); pc held stable for the whole request.
  - Posedge with ibusywait=1: stay in FETCH. pc must not change while ibusywait=1.
  - Posedge with ibusywait=0 and no redirect pending and redirect=0:
    - instr_out<=instruction, instr_valid<=1, fetch_count+1.
    - If stall=0: pc<=pc+4 and stay in FETCH (back-to-back hits sustain one instruction per cycle).
    - If stall=1: go to HOLD, iread<=0, pc unchanged.
- State HOLD:
  - iread=0; instr_out and instr_valid held.
  - When stall=0: pc<=pc+4, iread<=1, state->FETCH.
  - instr_valid stays 1 until the next fetch completes or a redirect occurs.
- Redirect handling (redirect has priority over stall):
  - redirect=1 in IDLE, HOLD, or FETCH with ibusywait=0:
    - pc<={redirect_pc[31:2],2'b00}, instr_valid<=0, state->FETCH.
    - Any word returned in that same cycle is discarded and not counted.
  - redirect=1 in FETCH with ibusywait=1:
    - Latch target and set the pending flag; pc unchanged; instr_valid<=0 immediately.
    - When ibusywait falls, discard the word, load the latched target into pc, clear the flag, stay FETCH with iread=1.
  - A second redirect while the flag is set overwrites the latched target (last wins).
- Arithmetic:
  - pc+4 is modulo 2^32: 32'hFFFFFFFC wraps to 0.
  - fetch_count does not wrap; it saturates.
- instr_valid deasserts only on reset or redirect. Otherwise every completed fetch rewrites instr_out.

Test Plan:
- Reset release, icache always hit (ibusywait=0), instruction=pc^32'hA5A50000:
  - One IDLE cycle, then pc=0,4,8,… on successive posedges.
  - instr_out tracks the data one cycle later; fetch_count increments each cycle.
- Miss on pc=0x10 (ibusywait=1 for 20 cycles):
  - pc stays 0x10 and iread stays 1 throughout.
  - On release, instr_out=word(0x10) and pc=0x14 next cycle.
- stall=1 for 5 cycles right after a fetch of pc=0x20 completes:
  - State HOLD, iread=0, instr_out=word(0x20), instr_valid=1, pc=0x20.
  - On stall=0, pc=0x24 and iread=1.
- redirect=1, redirect_pc=0x103 during a 10-cycle miss at 0x40:
  - instr_valid=0 next cycle; pc remains 0x40 until ibusywait=0.
  - Then pc=0x100; the 0x40 word is never presented and fetch_count is unchanged.
- pc=0xFFFFFFFC on hit: next pc=0x00000000.
- fetch_count preloaded near saturation (CNT_WIDTH=4, 20 hits): output stays 4'hF.
- reset asserted mid-miss:
  - All outputs return to reset values the following cycle.
  - Pending redirect is cleared; one IDLE cycle follows release.
